// File: rtl/biu_pkg.sv
// Shared definitions for the bus interface unit: master FSM states,
// control-field bit positions and the released-bus control value.
package biu_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ARB     = 5'b00010,
    REQ     = 5'b00100,
    WR_TURN = 5'b01000,
    RD_WAIT = 5'b10000
  } biu_master_state_t;

  localparam int BUS_CTRL_RNW   = 1;
  localparam int BUS_CTRL_VALID = 0;

  localparam logic [1:0] BUS_CTRL_IDLE = 2'bzz;

endpackage

// File: rtl/biu_master_if.sv
// Shared tri-state bus: address, data and control {rnw, data_valid}.
// Exactly one agent drives at a time; everyone else leaves it at 'z.
interface bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  wire [ADDR_WIDTH-1:0] address;
  wire [DATA_WIDTH-1:0] data;
  wire [1:0]            control;

  modport master (inout address, inout data, inout control);
  modport slave  (inout address, inout data, inout control);

endinterface

// File: rtl/biu_timeout_counter.sv
// Counts cycles while 'run' is high and flags the last allowed cycle so
// the master can abort a read nobody answers.
module biu_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Flags during the final waiting cycle, so the abort lands after exactly
  // TIMEOUT_CYCLES cycles of waiting.
  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/biu_master.sv
// Initiator side of the shared bus: arbitrates, drives one request beat,
// then waits for the slave's turnaround (write) or response beat (read).
// Optional read timeout abort: define BIU_MASTER_TIMEOUT_EN.
module biu_master
  import biu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_if.master                 bus,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  input  logic                  en,
  input  logic                  rnw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error
);

  biu_master_state_t     state_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rnw_q;
  logic                  done_q;
  logic                  error_q;
  logic                  drive;
  logic                  rsp_valid;
  logic                  timed_out;

  assign drive = (state_q == REQ);

  assign bus.address = drive ? address_q : 'z;
  assign bus.data    = drive ? data_q    : 'z;
  assign bus.control = drive ? {rnw_q, 1'b1} : BUS_CTRL_IDLE;

  // A floating or unknown valid bit compares as X and is not taken as a response.
  assign rsp_valid = (bus.control[BUS_CTRL_VALID] == 1'b1) &&
                     (bus.control[BUS_CTRL_RNW]   == 1'b1);

`ifdef BIU_MASTER_TIMEOUT_EN
  biu_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == REQ),
    .run    (state_q == RD_WAIT),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // Holding the request through the turnaround keeps other masters off the bus.
  assign bus_req  = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign data_out = data_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      address_q  <= '0;
      data_q     <= '0;
      rnw_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch reads the
      // pre-edge state and the pulse defaults below are safely overridden.
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) begin
            address_q <= address;
            data_q    <= data_in;
            rnw_q     <= rnw;
            state_q   <= ARB;
          end
        end
        ARB: begin
          if (bus_gnt) state_q <= REQ;
        end
        REQ: begin
          state_q <= rnw_q ? RD_WAIT : WR_TURN;
        end
        WR_TURN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        RD_WAIT: begin
          if (rsp_valid) begin
            data_out_q <= bus.data;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end else if (timed_out) begin
            data_out_q <= '1;
            done_q     <= 1'b1;
            error_q    <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_master.sv
// Self-checking bench for biu_master: behavioural slave on the shared bus,
// expected transactions queued at issue and popped at each done pulse.
module tb_biu_master;
  import biu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef BIU_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_gnt = 1'b0;
  logic          en = 1'b0;
  logic          rnw = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic          bus_req, busy, done, error;
  logic [DW-1:0] data_out;

  int            n_cmp = 0;
  int            n_bad = 0;
  txn_t          exp_q[$];
  logic [DW-1:0] last_rd = '0;

  // Behavioural slave state
  logic          slv_drv = 1'b0;
  logic          slv_en = 1'b0;
  logic          slv_pending = 1'b0;
  int            slv_cnt = 0;
  int            slv_delay = 1;
  logic          slv_respond = 1'b1;
  logic [DW-1:0] slv_rdata = '0;
  logic [AW-1:0] slv_addr = '0;
  logic [DW-1:0] slv_wdata = '0;
  logic          slv_rnw = 1'b0;

  bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  biu_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .bus_req (bus_req),
    .bus_gnt (bus_gnt),
    .en      (en),
    .rnw     (rnw),
    .address (address),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .data_out(data_out),
    .error   (error)
  );

  always #5 clk = ~clk;

  assign bus.data    = slv_drv ? slv_rdata : 'z;
  assign bus.control = slv_drv ? 2'b11 : 2'bzz;

  // Slave: captures a request beat, pulses slv_en the next cycle (RECV_REQ),
  // and for reads drives one response beat slv_delay cycles after that.
  // It ignores rst so a late response after a master reset still appears.
  always @(posedge clk) begin
    slv_en  <= 1'b0;
    slv_drv <= 1'b0;
    if (!slv_drv && bus.control[BUS_CTRL_VALID] === 1'b1) begin
      slv_en      <= 1'b1;
      slv_rnw     <= bus.control[BUS_CTRL_RNW];
      slv_addr    <= bus.address;
      slv_wdata   <= bus.data;
      slv_pending <= (bus.control[BUS_CTRL_RNW] === 1'b1) && slv_respond;
      slv_cnt     <= slv_delay - 1;
    end else if (slv_pending) begin
      if (slv_cnt == 0) begin
        slv_drv     <= 1'b1;
        slv_pending <= 1'b0;
      end else begin
        slv_cnt <= slv_cnt - 1;
      end
    end
  end

  // While the slave drives, the bus must carry exactly its values.
  always @(negedge clk) begin
    if (slv_drv) begin
      n_cmp++;
      if (bus.data !== slv_rdata || bus.control !== 2'b11) begin
        n_bad++;
        $display("FAIL bus_contention: data=%h ctrl=%b, want data=%h ctrl=11",
                 bus.data, bus.control, slv_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] rsp, input logic err);
    txn_t t;
    t.rnw = r; t.addr = a; t.wdata = d; t.rdata = rsp; t.err = err;
    exp_q.push_back(t);
    slv_rdata = rsp;
    en = 1'b1; rnw = r; address = a; data_in = d;
  endtask

  // Steps until done (bounded), checks arrival cycle, then scoreboards it.
  task automatic wait_done(input int start, input int exp_cyc, input string name);
    int            c;
    bit            seen;
    txn_t          t;
    logic [DW-1:0] want;
    c = start;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      c++;
      en = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_busy_wait: busy=%b in cycle %0d, want 1", name, busy, c);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_done_timeout: no done within 64 cycles", name);
      return;
    end
    if (c != exp_cyc) begin
      n_bad++;
      $display("FAIL %s_done_cycle: done in cycle %0d, want %0d", name, c, exp_cyc);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_scoreboard: done with empty expected queue", name);
      return;
    end
    t = exp_q.pop_front();
    want = t.err ? '1 : (t.rnw ? t.rdata : last_rd);
    if (data_out !== want) begin
      n_bad++;
      $display("FAIL %s_data_out: got %h, want %h", name, data_out, want);
    end
    last_rd = want;
    n_cmp++;
    if (error !== t.err || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_flags: error=%b busy=%b, want error=%b busy=0", name, error, busy, t.err);
    end
    n_cmp++;
    if (slv_addr !== t.addr || slv_rnw !== t.rnw || (!t.rnw && slv_wdata !== t.wdata)) begin
      n_bad++;
      $display("FAIL %s_slave_capture: addr=%h rnw=%b wdata=%h, want addr=%h rnw=%b wdata=%h",
               name, slv_addr, slv_rnw, slv_wdata, t.addr, t.rnw, t.wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        data_out !== '0 || bus.control[BUS_CTRL_VALID] === 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b req=%b done=%b err=%b dout=%h ctrl=%b, want all 0 and bus released",
               busy, bus_req, done, error, data_out, bus.control);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    bus_gnt = 1'b1; slv_delay = 1; slv_respond = 1'b1;
    issue(1'b0, 32'h10, 32'hA5A5_A5A5, '0, 1'b0);
    @(negedge clk); en = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b1 || busy !== 1'b1 || bus.control[BUS_CTRL_VALID] === 1'b1) begin
      n_bad++;
      $display("FAIL wr_arb_cycle: req=%b busy=%b ctrl=%b, want req=1 busy=1 bus released", bus_req, busy, bus.control);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.address !== 32'h10 || bus.data !== 32'hA5A5_A5A5 || bus.control !== 2'b01) begin
      n_bad++;
      $display("FAIL wr_req_beat: addr=%h data=%h ctrl=%b, want 00000010 a5a5a5a5 01", bus.address, bus.data, bus.control);
    end
    @(negedge clk);
    n_cmp++;
    if (slv_en !== 1'b1 || done !== 1'b0 || bus.control[BUS_CTRL_VALID] === 1'b1) begin
      n_bad++;
      $display("FAIL wr_turn_cycle: slv_en=%b done=%b ctrl=%b, want slv_en=1 done=0 bus released", slv_en, done, bus.control);
    end
    wait_done(3, 4, "wr");
  endtask

  task automatic test_read();
    bus_gnt = 1'b1; slv_delay = 3; slv_respond = 1'b1;
    issue(1'b1, 32'h100, '0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.address !== 32'h100 || bus.control !== 2'b11) begin
      n_bad++;
      $display("FAIL rd_req_beat: addr=%h ctrl=%b, want 00000100 11", bus.address, bus.control);
    end
    wait_done(2, 7, "rd");
  endtask

  task automatic test_arbitration();
    slv_delay = 1; bus_gnt = 1'b0;
    issue(1'b0, 32'h20, 32'h1234_5678, '0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); en = 1'b0;
      n_cmp++;
      if (bus_req !== 1'b1 || busy !== 1'b1 || bus.control[BUS_CTRL_VALID] === 1'b1) begin
        n_bad++;
        $display("FAIL arb_wait_%0d: req=%b busy=%b ctrl=%b, want req=1 busy=1 bus released", k, bus_req, busy, bus.control);
      end
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.address !== 32'h20 || bus.data !== 32'h1234_5678 || bus.control !== 2'b01) begin
      n_bad++;
      $display("FAIL arb_req_beat: addr=%h data=%h ctrl=%b, want 00000020 12345678 01", bus.address, bus.data, bus.control);
    end
    bus_gnt = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_bad++;
      $display("FAIL arb_req_hold: req=%b, want 1", bus_req);
    end
    wait_done(6, 8, "arb");
    bus_gnt = 1'b1;
  endtask

  task automatic test_back_to_back();
    bus_gnt = 1'b1; slv_delay = 1; slv_respond = 1'b1;
    issue(1'b0, 32'h4, 32'h0BAD_BEEF, '0, 1'b0);
    wait_done(0, 4, "b2b_wr");
    issue(1'b1, 32'h8, '0, 32'h5EED_F00D, 1'b0);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.address !== 32'h8 || bus.control !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_req_beat: addr=%h ctrl=%b, want 00000008 11", bus.address, bus.control);
    end
    wait_done(2, 5, "b2b_rd");
  endtask

  task automatic test_reset_mid_read();
    txn_t dropped;
    bus_gnt = 1'b1; slv_delay = 4; slv_respond = 1'b1;
    issue(1'b1, 32'h30, '0, 32'hDEAD_0001, 1'b0);
    dropped = exp_q.pop_back();
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_rd_wait: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
      n_bad++;
      $display("FAIL rst_abort: busy=%b req=%b done=%b dout=%h, want 0 0 0 00000000", busy, bus_req, done, data_out);
    end
    rst = 1'b0;
    last_rd = '0;
    for (int k = 6; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
        n_bad++;
        $display("FAIL rst_late_rsp_%0d: done=%b busy=%b dout=%h, want 0 0 00000000 (addr %h)",
                 k, done, busy, data_out, dropped.addr);
      end
    end
  endtask

`ifdef BIU_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bus_gnt = 1'b1; slv_respond = 1'b0;
    issue(1'b1, 32'h40, '0, '0, 1'b1);
    wait_done(0, 11, "timeout");
    slv_respond = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_read();
`ifdef BIU_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d transactions left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
